// File: rtl/mux21_arbiter.sv
// -----------------------------------------------------------------------------
// mux21_arbiter
//
// This block is a round-robin arbiter and sequencer for a shared W-bit 2:1
// datapath mux. Requesters A and B each send packets of one or more beats over
// a REQ/ACK handshake. One requester owns the path for a whole packet. The
// selected beat goes into a single registered output stage, which talks to the
// sink with VALID/READY.
//
// Ports
//   CLK     in   clock, rising edge
//   RST     in   synchronous reset, active-high
//   REQ_A   in   requester A presents a beat on A / LAST_A
//   A       in   requester A data [W-1:0]
//   LAST_A  in   current A beat ends the packet
//   ACK_A   out  A beat accepted this cycle (combinational)
//   REQ_B   in   requester B presents a beat on B / LAST_B
//   B       in   requester B data [W-1:0]
//   LAST_B  in   current B beat ends the packet
//   ACK_B   out  B beat accepted this cycle (combinational)
//   S       out  mux select, 1 only while B owns the path
//   BUSY    out  a requester currently owns the path
//   Y       out  registered output data [W-1:0]
//   LAST    out  registered end-of-packet flag for Y
//   VALID   out  Y / LAST hold a beat
//   READY   in   sink takes Y this cycle
// -----------------------------------------------------------------------------
module mux21_arbiter #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         REQ_A,
  input  logic [W-1:0] A,
  input  logic         LAST_A,
  output logic         ACK_A,
  input  logic         REQ_B,
  input  logic [W-1:0] B,
  input  logic         LAST_B,
  output logic         ACK_B,
  output logic         S,
  output logic         BUSY,
  output logic [W-1:0] Y,
  output logic         LAST,
  output logic         VALID,
  input  logic         READY
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_e;

  // This is the same function as the shared combinational mux21_2bit
  // datapath, widened to W bits.
  function automatic logic [W-1:0] mux21(input logic [W-1:0] d0,
                                         input logic [W-1:0] d1,
                                         input logic         sel);
    return sel ? d1 : d0;
  endfunction

  state_e         state_q, state_d;
  logic           pri_q, pri_d;        // 0: A preferred, 1: B preferred
  logic [W-1:0]   y_q, y_d;
  logic           last_q, last_d;
  logic           valid_q, valid_d;

  logic           sel;
  logic           can_load;
  logic           ack_a, ack_b;
  logic [W-1:0]   mux_data;
  logic           mux_last;

  assign sel      = (state_q == OWN_B);
  // The output stage can take a new beat when it is empty. It can also take
  // one when its current beat leaves in the same cycle.
  assign can_load = ~valid_q | READY;
  assign ack_a    = (state_q == OWN_A) & REQ_A & can_load;
  assign ack_b    = (state_q == OWN_B) & REQ_B & can_load;
  assign mux_data = mux21(A, B, sel);
  assign mux_last = sel ? LAST_B : LAST_A;

  // NOTE: every variable gets its hold value first. This way no path through
  // the case statement leaves a variable unassigned, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    pri_d   = pri_q;
    y_d     = y_q;
    last_d  = last_q;
    valid_d = valid_q;

    unique case (state_q)
      IDLE: begin
        // Contention goes to the preferred side. The grant is made here, so
        // no beat is accepted until the next cycle.
        if (REQ_A && (!REQ_B || !pri_q)) state_d = OWN_A;
        else if (REQ_B)                  state_d = OWN_B;
      end
      OWN_A: begin
        // The owner keeps the path until its LAST beat is taken. If REQ_A
        // drops mid-packet, the FSM simply waits here.
        if (ack_a && LAST_A) begin
          state_d = IDLE;
          pri_d   = 1'b1;
        end
      end
      OWN_B: begin
        if (ack_b && LAST_B) begin
          state_d = IDLE;
          pri_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (ack_a || ack_b) begin
      y_d     = mux_data;
      last_d  = mux_last;
      valid_d = 1'b1;
    end else if (valid_q && READY) begin
      valid_d = 1'b0;              // beat consumed, Y/LAST keep stale value
    end
  end

  // NOTE: state registers use non-blocking assignments. Every flop then
  // samples values from before the edge, whatever order the statements are in.
  always_ff @(posedge CLK) begin
    if (RST) begin
      // NOTE: the data register is reset as well, because Y must read zero
      // after reset. Any in-flight beat is dropped.
      state_q <= IDLE;
      pri_q   <= 1'b0;
      y_q     <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pri_q   <= pri_d;
      y_q     <= y_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  assign ACK_A = ack_a;
  assign ACK_B = ack_b;
  assign S     = sel;
  assign BUSY  = (state_q != IDLE);
  assign Y     = y_q;
  assign LAST  = last_q;
  assign VALID = valid_q;

endmodule

// File: tb/tb_mux21_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux21_arbiter
//
// Testbench for mux21_arbiter. Each table row describes one clock cycle: the
// inputs to drive, and the outputs expected at mid-cycle. After the table,
// hand-written sequences cover packet lock and reset in the middle of a packet.
// -----------------------------------------------------------------------------
module tb_mux21_arbiter;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST;
  logic         REQ_A, LAST_A, REQ_B, LAST_B, READY;
  logic [W-1:0] A, B;
  logic         ACK_A, ACK_B, S, BUSY, LAST, VALID;
  logic [W-1:0] Y;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  mux21_arbiter #(.W(W)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .REQ_A (REQ_A),
    .A     (A),
    .LAST_A(LAST_A),
    .ACK_A (ACK_A),
    .REQ_B (REQ_B),
    .B     (B),
    .LAST_B(LAST_B),
    .ACK_B (ACK_B),
    .S     (S),
    .BUSY  (BUSY),
    .Y     (Y),
    .LAST  (LAST),
    .VALID (VALID),
    .READY (READY)
  );

  // ctl = {rst, req_a, last_a, req_b, last_b, ready}
  // exp = {ack_a, ack_b, s, busy, last, valid}
  typedef struct packed {
    logic [5:0]   ctl;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [5:0]   exp;
    logic [W-1:0] y;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one cycle of inputs just after the rising edge, then returns at
  // the falling edge so the caller can sample outputs.
  task automatic drive(input logic [5:0] ctl, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    @(posedge CLK);
    #1;
    {RST, REQ_A, LAST_A, REQ_B, LAST_B, READY} = ctl;
    A = a;
    B = b;
    @(negedge CLK);
  endtask

  function automatic logic [15:0] outs();
    return {2'b00, ACK_A, ACK_B, S, BUSY, LAST, VALID, Y};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset is already active for the first edge, with both requests high.
    {RST, REQ_A, LAST_A, REQ_B, LAST_B, READY} = 6'b110101;
    A = '0;
    B = '0;

    // Reset held with both requests up. Release, then A wins with PRI=0.
    vq.push_back('{6'b110101, 8'h00, 8'h00, 6'b000000, 8'h00});
    vq.push_back('{6'b110101, 8'h00, 8'h00, 6'b000000, 8'h00});
    vq.push_back('{6'b011101, 8'h5A, 8'h00, 6'b000000, 8'h00});
    vq.push_back('{6'b011101, 8'h5A, 8'h00, 6'b100100, 8'h00});
    vq.push_back('{6'b000001, 8'h00, 8'h00, 6'b000011, 8'h5A});
    vq.push_back('{6'b000001, 8'h00, 8'h00, 6'b000010, 8'h5A});
    // Single A packet: 0x11, 0x22, 0x33(LAST).
    vq.push_back('{6'b010001, 8'h11, 8'h00, 6'b000010, 8'h5A});
    vq.push_back('{6'b010001, 8'h11, 8'h00, 6'b100110, 8'h5A});
    vq.push_back('{6'b010001, 8'h22, 8'h00, 6'b100101, 8'h11});
    vq.push_back('{6'b011001, 8'h33, 8'h00, 6'b100101, 8'h22});
    vq.push_back('{6'b000001, 8'h00, 8'h00, 6'b000011, 8'h33});
    vq.push_back('{6'b000001, 8'h00, 8'h00, 6'b000010, 8'h33});
    // Reset to bring PRI back to A before round-robin.
    vq.push_back('{6'b100001, 8'h00, 8'h00, 6'b000010, 8'h33});
    // Round-robin with 1-beat packets A=0x81, B=0x01.
    vq.push_back('{6'b011111, 8'h81, 8'h01, 6'b000000, 8'h00});
    vq.push_back('{6'b011111, 8'h81, 8'h01, 6'b100100, 8'h00});
    vq.push_back('{6'b011111, 8'h81, 8'h01, 6'b000011, 8'h81});
    vq.push_back('{6'b011111, 8'h81, 8'h01, 6'b011110, 8'h81});
    vq.push_back('{6'b011111, 8'h81, 8'h01, 6'b000011, 8'h01});
    vq.push_back('{6'b011111, 8'h81, 8'h01, 6'b100110, 8'h01});
    vq.push_back('{6'b011111, 8'h81, 8'h01, 6'b000011, 8'h81});
    vq.push_back('{6'b011111, 8'h81, 8'h01, 6'b011110, 8'h81});
    vq.push_back('{6'b000001, 8'h00, 8'h00, 6'b000011, 8'h01});
    vq.push_back('{6'b000001, 8'h00, 8'h00, 6'b000010, 8'h01});
    // Backpressure: A packet 0x49, 0x01(LAST), READY low for 3 cycles.
    vq.push_back('{6'b010001, 8'h49, 8'h00, 6'b000010, 8'h01});
    vq.push_back('{6'b010001, 8'h49, 8'h00, 6'b100110, 8'h01});
    vq.push_back('{6'b011000, 8'h01, 8'h00, 6'b000101, 8'h49});
    vq.push_back('{6'b011000, 8'h01, 8'h00, 6'b000101, 8'h49});
    vq.push_back('{6'b011000, 8'h01, 8'h00, 6'b000101, 8'h49});
    vq.push_back('{6'b011001, 8'h01, 8'h00, 6'b100101, 8'h49});
    vq.push_back('{6'b000001, 8'h00, 8'h00, 6'b000011, 8'h01});
    vq.push_back('{6'b000001, 8'h00, 8'h00, 6'b000010, 8'h01});

    foreach (vq[i]) begin
      drive(vq[i].ctl, vq[i].a, vq[i].b);
      check($sformatf("vec%0d", i), outs(), {2'b00, vq[i].exp, vq[i].y});
    end

    // Packet lock. PRI is now 1, so A must ask alone to win the grant.
    drive(6'b010001, 8'h98, 8'h00);
    check("lock_grant_busy", {15'd0, BUSY}, 16'd0);
    drive(6'b010111, 8'h98, 8'h77);
    check("lock_ack_a", {14'd0, ACK_A, S}, 16'b10);
    for (int k = 0; k < 4; k++) begin
      drive(6'b000111, 8'h00, 8'h77);
      check($sformatf("lock_gap%0d", k), {13'd0, ACK_A, ACK_B, S}, 16'b000);
    end
    drive(6'b011111, 8'h00, 8'h77);
    check("lock_last_a", {14'd0, ACK_A, ACK_B}, 16'b10);
    drive(6'b000111, 8'h00, 8'h77);
    check("lock_idle", {5'd0, BUSY, ACK_B, LAST, VALID, Y}, {5'd0, 4'b0011, 8'h00});
    drive(6'b000111, 8'h00, 8'h77);
    check("lock_b_grant", {14'd0, S, ACK_B}, 16'b11);
    drive(6'b000001, 8'h00, 8'h00);
    check("lock_b_out", {7'd0, VALID, Y}, {7'd0, 1'b1, 8'h77});

    // Reset mid-packet. A 1-beat A packet first sets PRI=1, so the reset
    // has a preference to clear.
    drive(6'b011001, 8'hC3, 8'h00);
    drive(6'b011001, 8'hC3, 8'h00);
    check("rmp_pre_ack_a", {15'd0, ACK_A}, 16'd1);
    drive(6'b000101, 8'h00, 8'hB1);
    drive(6'b000101, 8'h00, 8'hB1);
    check("rmp_beat1", {14'd0, S, ACK_B}, 16'b11);
    drive(6'b000101, 8'h00, 8'hB2);
    check("rmp_beat2", {7'd0, ACK_B, Y}, {7'd0, 1'b1, 8'hB1});
    drive(6'b100101, 8'h00, 8'hB3);
    drive(6'b010101, 8'hD4, 8'hB3);
    check("rmp_after_rst", outs(), 16'h0000);
    drive(6'b011101, 8'hD4, 8'hB3);
    check("rmp_pri_a", {13'd0, S, BUSY, ACK_A}, 16'b011);
    drive(6'b000001, 8'h00, 8'h00);
    check("rmp_out", {6'd0, LAST, VALID, Y}, {6'd0, 2'b11, 8'hD4});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
